// File: rtl/al_accel_wload.sv
// ---------------------------------------------------------------------------
// al_accel_wload
//
// Weight loader between a SoC byte source (bus / DMA) and the accelerator's
// 3-lane, 8-bit weight register. Bytes arrive over a valid/ready handshake
// and are packed three at a time into one weight row: lane 0 takes the first
// byte, lane 1 the second and lane 2 the third. Each completed row is offered
// to the weight register with a load enable that is gated by the
// accelerator's ready. This repeats for a programmed number of rows, and then
// a one-cycle done pulse is raised.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      one-cycle load request, honoured only when idle
//   num_rows   in   CNT_W  rows to load, sampled with an accepted start
//   busy       out  1      loader is not idle
//   done       out  1      one-cycle pulse at the end of a load
//   s_data     in   8      weight byte from the source
//   s_valid    in   1      s_data is valid
//   s_ready    out  1      loader accepts a byte this cycle
//   wreg_do_0  out  8      lane 0 weight (first byte of a row)
//   wreg_do_1  out  8      lane 1 weight (second byte of a row)
//   wreg_do_2  out  8      lane 2 weight (third byte of a row)
//   wreg_enb   out  1      load enable to the weight register
//   acc_ready  in   1      accelerator permits a weight load this cycle
//   row_idx    out  CNT_W  index of the row being collected or issued
// ---------------------------------------------------------------------------
module al_accel_wload #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       wreg_do_0,
  output logic [7:0]       wreg_do_1,
  output logic [7:0]       wreg_do_2,
  output logic             wreg_enb,
  input  logic             acc_ready,
  output logic [CNT_W-1:0] row_idx
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_num_rows;
  logic [CNT_W-1:0] r_row_idx;
  logic [7:0]       r_lane0;
  logic [7:0]       r_lane1;
  logic [7:0]       r_lane2;

  logic             w_start_load;
  logic             w_start_empty;
  logic             w_accept;
  logic             w_row_full;
  logic             w_issue_fire;
  logic             w_last_row;

  // A start is only looked at in IDLE; a zero row count skips straight to
  // DONE so the caller still gets its completion pulse.
  assign w_start_load  = (r_state == ST_IDLE) && start && (num_rows != '0);
  assign w_start_empty = (r_state == ST_IDLE) && start && (num_rows == '0);

  // s_ready is a pure function of state, so the handshake is simply
  // s_valid qualified by being in COLLECT.
  assign w_accept     = s_valid && (r_state == ST_COLLECT);
  assign w_row_full   = w_accept && (r_byte_cnt == 2'd2);
  assign w_issue_fire = (r_state == ST_ISSUE) && acc_ready;

  // The latched count is never zero during a load, so the subtraction
  // cannot underflow; row_idx therefore stops at num_rows-1 and never wraps.
  assign w_last_row = (r_row_idx == (r_num_rows - CNT_W'(1)));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    s_ready     = 1'b0;
    wreg_enb    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_start_load) begin
          w_state_nxt = ST_COLLECT;
        end else if (w_start_empty) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_COLLECT: begin
        s_ready = 1'b1;
        if (w_row_full) begin
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // The enable follows acc_ready combinationally so the weight
        // register loads in exactly the cycle the accelerator allows it.
        wreg_enb = acc_ready;
        if (w_issue_fire) begin
          w_state_nxt = w_last_row ? ST_DONE : ST_COLLECT;
        end
      end

      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load bookkeeping: latched row count, row index and byte position
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_rows <= '0;
      r_row_idx  <= '0;
      r_byte_cnt <= 2'd0;
    end else begin
      if (w_start_load) begin
        // num_rows is captured once here; later changes on the port are
        // irrelevant for the rest of the load.
        r_num_rows <= num_rows;
        r_row_idx  <= '0;
        r_byte_cnt <= 2'd0;
      end else if (w_accept) begin
        r_byte_cnt <= (r_byte_cnt == 2'd2) ? 2'd0 : (r_byte_cnt + 2'd1);
      end

      if (w_issue_fire && !w_last_row) begin
        r_row_idx <= r_row_idx + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lane registers
  // -------------------------------------------------------------------------
  // Each accepted byte goes straight into its lane, so between bytes the
  // lanes mix the new row with the previous one. That is harmless because
  // the weight register only loads under wreg_enb, and during ISSUE no byte
  // is accepted, so the lanes are stable for the whole issue window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane0 <= 8'h00;
      r_lane1 <= 8'h00;
      r_lane2 <= 8'h00;
    end else if (w_accept) begin
      unique case (r_byte_cnt)
        2'd0:    r_lane0 <= s_data;
        2'd1:    r_lane1 <= s_data;
        2'd2:    r_lane2 <= s_data;
        default: ;
      endcase
    end
  end

  assign wreg_do_0 = r_lane0;
  assign wreg_do_1 = r_lane1;
  assign wreg_do_2 = r_lane2;
  assign row_idx   = r_row_idx;

endmodule

// File: doc/al_accel_wload.md
Name: al_accel_wload

Overview:
- Weight loader feeding the accelerator weight register (3-lane, 8-bit) from the SoC side.
- Accepts a byte stream over a valid/ready handshake and packs each group of 3 consecutive bytes into one 3-lane weight row.
- Presents each row with a load-enable pulse gated by the accelerator's ready, for a programmed number of rows, then signals done.
- Sits between the SoC bus/DMA byte source and the weight register's data/enable inputs.

Parameters:
- CNT_W, 8, width of row count and row index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- num_rows  input  CNT_W  rows to load; sampled on accepted start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of load.
- s_data  input  8  weight byte from source.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader can accept a byte.
- wreg_do_0  output  8  lane 0 weight (first byte of a row).
- wreg_do_1  output  8  lane 1 weight (second byte).
- wreg_do_2  output  8  lane 2 weight (third byte).
- wreg_enb  output  1  load enable to weight register.
- acc_ready  input  1  accelerator permits a weight-register load this cycle.
- row_idx  output  CNT_W  index of the row currently being collected or issued.

Behaviour:
- Reset (async, any time, including mid-load):
  - state to IDLE.
  - wreg_do_0/1/2, row_idx, internal byte count and latched num_rows to 0.
  - busy, done, s_ready and wreg_enb to 0.
  - Partially collected row is discarded.
- States: IDLE, COLLECT, ISSUE, DONE.
- IDLE:
  - s_ready=0, wreg_enb=0.
  - start=1 with num_rows!=0: latch num_rows, clear byte count and row_idx, go to COLLECT.
  - start=1 with num_rows==0: go to DONE without touching the stream.
- COLLECT:
  - s_ready=1 combinationally.
  - Byte accepted when s_valid && s_ready.
  - Byte count 0/1/2 writes s_data into wreg_do_0/1/2 respectively on that clock edge.
  - Accepting the byte at count 2 resets the count to 0 and moves to ISSUE.
  - s_valid low stalls with no state change.
- ISSUE:
  - s_ready=0.
  - wreg_enb = acc_ready, combinational and only in this state.
  - wreg_do_0/1/2 stable throughout.
  - On the cycle acc_ready=1:
    - if row_idx == latched num_rows-1, go to DONE;
    - else increment row_idx and go to COLLECT.
  - acc_ready low holds ISSUE indefinitely.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; it is not queued.
- num_rows changes after start have no effect.
- wreg_do_0/1/2 hold their last values in IDLE/DONE.
  - Consumers rely on wreg_enb only, never on data changes.
  - Lanes update per byte during COLLECT, so lanes are mixed-row until ISSUE.
- Latency and throughput:
  - With continuous s_valid and acc_ready, the third byte accepted at edge N gives ISSUE and wreg_enb=1 in cycle N+1.
  - Throughput is 1 row per 4 cycles.
  - done asserts in the cycle after the final wreg_enb.
- Row counting is unsigned.
  - num_rows = 2^CNT_W-1 is the maximum.
  - row_idx never wraps within a load.
- Simultaneous start and reset: reset wins.

Test Plan:
- Reset then start, num_rows=3, bytes 0x01..0x09 streamed with s_valid constant, acc_ready=1:
  - three wreg_enb pulses with lanes (01,02,03), (04,05,06), (07,08,09);
  - done pulses one cycle after the third pulse;
  - busy drops with done; row_idx was 0,1,2.
- num_rows=1, acc_ready held 0 for 5 cycles after third byte:
  - ISSUE held, s_ready=0, wreg_enb=0, lanes stable;
  - acc_ready=1 gives a single wreg_enb, then done.
- s_valid toggled every other cycle, num_rows=2, bytes 0xA0..0xA5:
  - only handshaked bytes captured;
  - rows (A0,A1,A2) and (A3,A4,A5).
- start with num_rows=0: done pulses next cycle, s_ready never asserts, no wreg_enb.
- reset asserted after 2 of 3 bytes of row 0:
  - immediately all outputs 0 and IDLE;
  - a new start with num_rows=1 and bytes 11,22,33 loads (11,22,33) with no leftover bytes.
- start pulsed while busy with a different num_rows: ignored; the original row count completes.
